booth_mult_sequencer: RTL

//  - Moore/Mealy FSM that sequences the radix-2 Booth multiplier datapath (mult_with_no_fsm).
//  - Generates its load_A, load_B, load_add, add_sub and shift_HQ_LQ_Q_1 strobes from the Q_LSB feedback.
//  - Sits between the operand-entry FSM, which issues start/abort, and the multiplier; reports busy/done/result_valid.
//  - Downstream consumers: display/output control.

---
 rtl/booth_ctrl_pkg.sv | 22 ++
 rtl/booth_mult_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/booth_ctrl_pkg.sv
// Shared types for the radix-2 Booth multiplier sequencer: FSM state encoding
// and the {Q[0], Q_-1} recoding constants.
package booth_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  function automatic logic is_nop(input logic [1:0] q_lsb);
    return (q_lsb == BOOTH_NOP0) || (q_lsb == BOOTH_NOP1);
  endfunction

endpackage

// File: rtl/booth_mult_sequencer.sv
// Control FSM for the radix-2 Booth multiplier datapath. Define SKIP_NOP_EN to
// jump straight to SHIFT on 00/11 recodings instead of visiting ADD every iteration.
module booth_mult_sequencer
  import booth_ctrl_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] Q_LSB,
  output logic       load_A,
  output logic       load_B,
  output logic       load_add,
  output logic       add_sub,
  output logic       shift_HQ_LQ_Q_1,
  output logic       busy,
  output logic       done,
  output logic       result_valid,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = $clog2(N_BITS + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             skip_add;

  // Skip path only exists when enabled; otherwise every iteration visits ADD.
`ifdef SKIP_NOP_EN
  assign skip_add = is_nop(Q_LSB);
`else
  assign skip_add = 1'b0;
`endif

  // Handshake: start is a request accepted only in IDLE (no queueing while busy);
  // abort is an unconditional cancel that wins over start in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
    end else if (abort) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            result_valid <= 1'b0;
          end
        end
        LOAD: begin
          cnt   <= CNT_W'(N_BITS);
          state <= skip_add ? SHIFT : ADD;
        end
        ADD: begin
          state <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt > CNT_W'(1)) begin
            state <= skip_add ? SHIFT : ADD;
          end else begin
            // result_valid rises together with the done pulse.
            state        <= DONE;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    load_A          = 1'b0;
    load_B          = 1'b0;
    load_add        = 1'b0;
    add_sub         = 1'b0;
    shift_HQ_LQ_Q_1 = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      LOAD: begin
        load_A = 1'b1;
        load_B = 1'b1;
        busy   = 1'b1;
      end
      ADD: begin
        busy = 1'b1;
        if (Q_LSB == BOOTH_ADD || Q_LSB == BOOTH_SUB) begin
          load_add = 1'b1;
          add_sub  = (Q_LSB == BOOTH_ADD);
        end
      end
      SHIFT: begin
        shift_HQ_LQ_Q_1 = 1'b1;
        busy            = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dbg_state = state;

endmodule
